// File: rtl/spi_flash_pkg.sv
// Shared constants and FSM encoding for the single-byte SPI flash initiator.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam int unsigned DefClkDiv = 2;
  localparam int unsigned DefAddrW  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StDone
  } state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period counter: one-cycle rise/fall strobes and the registered SPI clock (mode 0).
module spi_sck_gen
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV = DefClkDiv
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic active_i,
  output logic tick_o,
  output logic rise_en_o,
  output logic fall_en_o,
  output logic sck_o
);

  localparam int unsigned CntW = $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sck_q, sck_d;

  // tick marks the end of every half period; SCK only moves while active (SHIFT).
  always_comb begin
    tick_o    = en_i && (cnt_q == CntMax);
    rise_en_o = tick_o && active_i && !sck_q;
    fall_en_o = tick_o && active_i && sck_q;
    cnt_d     = '0;
    sck_d     = 1'b0;
    if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
      sck_d = rise_en_o ? 1'b1 : (fall_en_o ? 1'b0 : sck_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o = sck_q;

endmodule

// File: rtl/spi_flash_master.sv
// SPI mode-0 initiator running one READ/WRITE frame {cmd, addr, data} per start request.
module spi_flash_master
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV = DefClkDiv,
  parameter int unsigned ADDR_W  = DefAddrW
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              done,
  output logic              SCK,
  output logic              S,
  output logic              MOSI,
  input  logic              MISO,
  output logic              W_ENABLE
);

  localparam int unsigned N     = 16 + ADDR_W;
  localparam int unsigned BitW  = $clog2(N);
  localparam int unsigned HoldW = $clog2(CLK_DIV + 1);
  localparam logic [BitW-1:0]  LastBit = BitW'(N - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(CLK_DIV - 1);

  state_e            state_q, state_d;
  logic [N-1:0]      tx_q, tx_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              wr_q, wr_d;
  logic              s_q, s_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mosi_q, mosi_d;
  logic              wen_q, wen_d;
  logic              sck_en, tick, rise_en, fall_en;

  assign sck_en = (state_q == StSetup) || (state_q == StShift);

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk_i    (clk),
    .rst_ni   (RESET),
    .en_i     (sck_en),
    .active_i (state_q == StShift),
    .tick_o   (tick),
    .rise_en_o(rise_en),
    .fall_en_o(fall_en),
    .sck_o    (SCK)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    wr_d    = wr_q;
    s_d     = s_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mosi_d  = mosi_q;
    wen_d   = wen_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          tx_d    = {(wr ? CMD_WRITE : CMD_READ), addr, (wr ? wdata : 8'h00)};
          wr_d    = wr;
          s_d     = 1'b0;
          busy_d  = 1'b1;
          wen_d   = wr;
          mosi_d  = tx_d[N-1];
          bit_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (tick) state_d = StShift;
      end
      StShift: begin
        if (rise_en) rx_d = {rx_q[6:0], MISO};
        if (fall_en) begin
          if (bit_q == LastBit) begin
            mosi_d  = 1'b0;
            hold_d  = '0;
            state_d = StHold;
          end else begin
            tx_d   = tx_q << 1;
            mosi_d = tx_q[N-2];
            bit_d  = bit_q + BitW'(1);
          end
        end
      end
      StHold: begin
        if (hold_q == HoldMax) begin
          s_d     = 1'b1;
          wen_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Earlier MISO bits have already fallen off the 8-bit receive register.
          if (!wr_q) rdata_d = rx_q;
          state_d = StDone;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      wr_q    <= 1'b0;
      s_q     <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mosi_q  <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      wr_q    <= wr_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mosi_q  <= mosi_d;
      wen_q   <= wen_d;
    end
  end

  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign S        = s_q;
  assign MOSI     = mosi_q;
  assign W_ENABLE = wen_q;

endmodule

// File: tb/tb_spi_flash_master.sv
// Scoreboard bench: default instance (CLK_DIV=2, ADDR_W=8) and a CLK_DIV=1, ADDR_W=16 instance.
module tb_spi_flash_master;

  typedef struct {
    int         inst;
    logic [39:0] frame;
    int         nbits;
    logic       wr;
    logic [7:0] rdata;
    int         lat;
    int         start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic RESET = 1'b1;
  logic [1:0]       start_v, wr_v, busy_v, done_v, sck_v, ss_v, mosi_v, wen_v;
  logic [1:0]       miso_v = '0;
  logic [1:0][15:0] addr_v;
  logic [1:0][7:0]  wdata_v, rdata_v;

  always #5 clk = ~clk;

  spi_flash_master u_dut0 (
    .clk(clk), .RESET(RESET), .start(start_v[0]), .wr(wr_v[0]), .addr(addr_v[0][7:0]),
    .wdata(wdata_v[0]), .rdata(rdata_v[0]), .busy(busy_v[0]), .done(done_v[0]), .SCK(sck_v[0]),
    .S(ss_v[0]), .MOSI(mosi_v[0]), .MISO(miso_v[0]), .W_ENABLE(wen_v[0])
  );

  spi_flash_master #(.CLK_DIV(1), .ADDR_W(16)) u_dut1 (
    .clk(clk), .RESET(RESET), .start(start_v[1]), .wr(wr_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .rdata(rdata_v[1]), .busy(busy_v[1]), .done(done_v[1]), .SCK(sck_v[1]),
    .S(ss_v[1]), .MOSI(mosi_v[1]), .MISO(miso_v[1]), .W_ENABLE(wen_v[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t exp_q[$];
  int   compared = 0, mismatched = 0;
  int   tmo_cnt = 0, tmo_seen = 0;
  int   done_seen [2];

  // Flash contents before any write; the reference and the flash model share this preload.
  function automatic logic [7:0] init_byte(int g, logic [15:0] a);
    if (a == 16'h0010) return 8'hA7;
    return 8'(int'(a) * 37 + g * 91 + 92);
  endfunction

  bit [7:0] ref_mem [2][65536];
  bit       ref_wr  [2][65536];
  logic [7:0] last_rd [2];

  function automatic logic [7:0] ref_rd(int g, logic [15:0] a);
    return ref_wr[g][a] ? ref_mem[g][a] : init_byte(g, a);
  endfunction

  bit [7:0] fmem [2][65536];
  bit       fwr  [2][65536];
  logic [1:0]  sck_prev = '0, in_frame = '0, wen0 = '0, wen_chg = '0, busy_bad = '0;
  logic [1:0]  prev_done = '0;
  int          nb [2], cap_n [2];
  logic [39:0] bits [2], cap_bits [2];
  logic [15:0] cur_addr [2];
  logic [7:0]  byte_m;
  int          aw_m;
  exp_t        e_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Flash model plus monitor: decodes the serial pins and scores each done pulse.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      aw_m = (g == 0) ? 8 : 16;
      if (!RESET) begin
        chk("rst_S", ss_v[g], 1'b1);
        chk("rst_SCK", sck_v[g], 1'b0);
        chk("rst_MOSI", mosi_v[g], 1'b0);
        chk("rst_W_ENABLE", wen_v[g], 1'b0);
        chk("rst_busy", busy_v[g], 1'b0);
        chk("rst_done", done_v[g], 1'b0);
        chk("rst_rdata", rdata_v[g], 8'h00);
      end
      if (!ss_v[g]) begin
        if (!in_frame[g]) begin
          in_frame[g] = 1'b1; nb[g] = 0; bits[g] = '0;
          wen0[g] = wen_v[g]; wen_chg[g] = 1'b0; busy_bad[g] = 1'b0;
        end
        if (wen_v[g] !== wen0[g]) wen_chg[g] = 1'b1;
        if (busy_v[g] !== 1'b1) busy_bad[g] = 1'b1;
        if (sck_v[g] && !sck_prev[g]) begin
          bits[g] = {bits[g][38:0], mosi_v[g]};
          nb[g]++;
        end
        if (!sck_v[g] && sck_prev[g]) begin
          if (nb[g] == 8 + aw_m) cur_addr[g] = (g == 0) ? {8'h00, bits[g][7:0]} : bits[g][15:0];
          if (nb[g] >= 8 + aw_m && nb[g] < 16 + aw_m) begin
            byte_m = fwr[g][cur_addr[g]] ? fmem[g][cur_addr[g]] : init_byte(g, cur_addr[g]);
            miso_v[g] = byte_m[7 - (nb[g] - 8 - aw_m)];
          end else begin
            miso_v[g] = 1'($urandom);
          end
        end
      end else if (in_frame[g]) begin
        in_frame[g] = 1'b0;
        cap_bits[g] = bits[g];
        cap_n[g] = nb[g];
        if (nb[g] == 16 + aw_m && wen0[g] && !wen_chg[g] && 8'(bits[g] >> (8 + aw_m)) == 8'h02)
        begin
          fmem[g][cur_addr[g]] = bits[g][7:0];
          fwr[g][cur_addr[g]] = 1'b1;
        end
      end
      sck_prev[g] = sck_v[g];

      if (done_v[g]) begin
        chk("done_pulse_width", prev_done[g], 1'b0);
        if (exp_q.size() == 0 || exp_q[0].inst != g) begin
          compared++; mismatched++;
          $display("FAIL unexpected_done inst%0d: got done=1, expected 0 (t=%0t)", g, $time);
        end else begin
          e_m = exp_q.pop_front();
          chk("rdata", rdata_v[g], e_m.rdata);
          chk("done_latency", cyc - e_m.start_cyc, e_m.lat);
          chk("mosi_frame", cap_bits[g], e_m.frame);
          chk("sck_pulses", cap_n[g], e_m.nbits);
          chk("w_enable_level", wen0[g], e_m.wr);
          chk("w_enable_steady", wen_chg[g], 1'b0);
          chk("busy_during_frame", busy_bad[g], 1'b0);
          chk("busy_at_done", busy_v[g], 1'b0);
        end
        done_seen[g]++;
      end
      prev_done[g] = done_v[g];
    end
    if (tmo_cnt != tmo_seen) begin
      compared++; mismatched++;
      $display("FAIL done_timeout: got no done within bound, expected done (t=%0t)", $time);
      tmo_seen = tmo_cnt;
    end
  end

  task automatic run_frame(input int inst, input logic wr, input logic [15:0] a,
                           input logic [7:0] wd, input bit extra, input bit rst_mid);
    int aw, n, s, seen0;
    exp_t e;
    logic [7:0] cmd;
    aw = (inst == 0) ? 8 : 16;
    n = 16 + aw;
    if (inst == 0) a[15:8] = '0;
    cmd = wr ? 8'h02 : 8'h03;
    e.inst = inst; e.nbits = n; e.wr = wr;
    e.lat = ((inst == 0) ? 2 : 1) * (2 * n + 2) + 1;
    e.frame = (40'(cmd) << (aw + 8)) | (40'(a) << 8) | 40'(wr ? wd : 8'h00);
    if (wr) begin
      if (!rst_mid) begin ref_mem[inst][a] = wd; ref_wr[inst][a] = 1'b1; end
      e.rdata = last_rd[inst];
    end else begin
      e.rdata = ref_rd(inst, a);
      last_rd[inst] = e.rdata;
    end
    @(negedge clk);
    wr_v[inst] = wr; addr_v[inst] = a; wdata_v[inst] = wd; start_v[inst] = 1'b1;
    s = cyc;
    e.start_cyc = s;
    exp_q.push_back(e);
    seen0 = done_seen[inst];
    for (int k = 0; k < 600 && done_seen[inst] == seen0; k++) begin
      @(negedge clk);
      start_v[inst] = extra && (cyc == s + 5 || cyc == s + 40);
      if (start_v[inst]) begin
        wr_v[inst] = 1'($urandom); addr_v[inst] = 16'($urandom); wdata_v[inst] = 8'($urandom);
      end
      if (rst_mid && cyc == s + 50) begin
        @(posedge clk); #1 RESET = 1'b0;
        @(posedge clk); #1 RESET = 1'b1;
        void'(exp_q.pop_back());
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        repeat (3) @(negedge clk);
        return;
      end
    end
    start_v[inst] = 1'b0;
    if (done_seen[inst] == seen0) begin
      tmo_cnt++;
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  logic [15:0] ra;

  initial begin
    start_v = '0; wr_v = '0; addr_v = '0; wdata_v = '0;
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    done_seen[0] = 0; done_seen[1] = 0;
    #1 RESET = 1'b0;
    repeat (3) @(negedge clk);
    #1 RESET = 1'b1;

    run_frame(0, 1'b1, 16'h005A, 8'hC3, 1'b0, 1'b0);
    run_frame(0, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0);
    run_frame(0, 1'b0, 16'h005A, 8'h00, 1'b0, 1'b0);
    run_frame(0, 1'b0, 16'($urandom), 8'h00, 1'b1, 1'b0);
    run_frame(0, 1'b1, 16'h0033, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      run_frame(0, 1'($urandom), 16'($urandom_range(0, 15)), 8'($urandom), 1'b0, 1'b0);
    ra = 16'h0044;
    run_frame(0, 1'b1, ra, 8'h9E, 1'b0, 1'b1);
    run_frame(0, 1'b0, ra, 8'h00, 1'b0, 1'b0);

    run_frame(1, 1'b0, 16'h0123, 8'h00, 1'b0, 1'b0);
    ra = 16'($urandom);
    run_frame(1, 1'b1, ra, 8'($urandom), 1'b0, 1'b0);
    run_frame(1, 1'b0, ra, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_frame(1, 1'($urandom), 16'($urandom_range(0, 7)), 8'($urandom), 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
